// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator behind a command/response port,
// with a per-transaction timeout that aborts a hung slave.
module axi_lite_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [2:0]        m_axi_awprot,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [2:0]        m_axi_arprot,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA} state_t;
  state_t state_q, state_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [1:0] resp_q, resp_d;
  logic rsp_q, rsp_d, to_q, to_d;
  logic aw_all, w_all, expire;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      rsp_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      rsp_q     <= rsp_d;
      to_q      <= to_d;
    end
  end
  always_comb begin
    aw_all    = aw_done_q | (m_axi_awvalid & m_axi_awready);
    w_all     = w_done_q | (m_axi_wvalid & m_axi_wready);
    expire    = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_q >= CW'(TIMEOUT - 1));
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    rsp_d     = 1'b0;
    to_d      = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d    = cmd_addr;
        wdata_d   = cmd_wdata;
        wstrb_d   = cmd_wstrb;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = cmd_write ? WRITE : RADDR;
      end
      WRITE: begin
        aw_done_d = aw_all;
        w_done_d  = w_all;
        state_d   = (aw_all && w_all) ? WRESP : WRITE;
      end
      WRESP: if (m_axi_bvalid) begin
        rsp_d   = 1'b1;
        resp_d  = m_axi_bresp;
        state_d = IDLE;
      end
      RADDR: state_d = m_axi_arready ? RDATA : RADDR;
      RDATA: if (m_axi_rvalid) begin
        rsp_d   = 1'b1;
        resp_d  = m_axi_rresp;
        rdata_d = m_axi_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a handshake that moves the FSM on in the expiry cycle beats the timeout
    if (expire && state_d == state_q) begin
      state_d = IDLE;
      rsp_d   = 1'b1;
      to_d    = 1'b1;
      resp_d  = 2'b10;
    end
  end
  always_comb begin
    cmd_ready     = state_q == IDLE;
    m_axi_awvalid = (state_q == WRITE) && !aw_done_q;
    m_axi_wvalid  = (state_q == WRITE) && !w_done_q;
    m_axi_bready  = state_q == WRESP;
    m_axi_arvalid = state_q == RADDR;
    m_axi_rready  = state_q == RDATA;
    m_axi_awaddr  = addr_q;
    m_axi_araddr  = addr_q;
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = wstrb_q;
    m_axi_awprot  = 3'b000;
    m_axi_arprot  = 3'b000;
    rsp_valid     = rsp_q;
    rsp_timeout   = to_q;
    rsp_resp      = resp_q;
    rsp_rdata     = rdata_q;
  end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: table vectors, randomized commands against a word-array/latency model,
// and hand sequences for timeout, async reset and back-to-back corners.
module tb_axi_lite_master;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic [3:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  always #5 clk = ~clk;
  axi_lite_master #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );
  // slave stub: programmable ready/valid delays over a 16-word memory
  int aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
  logic [1:0] sresp = 2'b00;
  logic hang_ar = 1'b0, hang_b = 1'b0;
  logic [31:0] mem [16];
  int aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic aw_got, w_got, ar_got;
  logic [31:0] aw_a, w_dat, ar_a;
  logic [3:0] w_s;
  assign m_axi_awready = m_axi_awvalid && aw_wait >= aw_d;
  assign m_axi_wready  = m_axi_wvalid && w_wait >= w_d;
  assign m_axi_arready = m_axi_arvalid && !hang_ar && ar_wait >= ar_d;
  assign m_axi_bvalid  = aw_got && w_got && !hang_b && b_wait >= b_d;
  assign m_axi_bresp   = sresp;
  assign m_axi_rvalid  = ar_got && r_wait >= r_d;
  assign m_axi_rdata   = mem[ar_a[5:2]];
  assign m_axi_rresp   = sresp;
  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_a <= '0; w_dat <= '0; w_s <= '0; ar_a <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      aw_wait <= (m_axi_awvalid && !m_axi_awready) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !m_axi_wready) ? w_wait + 1 : 0;
      ar_wait <= (m_axi_arvalid && !m_axi_arready) ? ar_wait + 1 : 0;
      b_wait  <= (aw_got && w_got && !(m_axi_bvalid && m_axi_bready)) ? b_wait + 1 : 0;
      r_wait  <= (m_axi_arvalid && m_axi_arready) ? 0 :
                 (ar_got && !(m_axi_rvalid && m_axi_rready)) ? r_wait + 1 : 0;
      if (m_axi_awvalid && m_axi_awready) begin aw_got <= 1'b1; aw_a <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin w_got <= 1'b1; w_dat <= m_axi_wdata; w_s <= m_axi_wstrb; end
      if (m_axi_bvalid && m_axi_bready) begin
        aw_got <= 1'b0;
        w_got <= 1'b0;
        for (int i = 0; i < 4; i++) if (w_s[i]) mem[aw_a[5:2]][i*8 +: 8] <= w_dat[i*8 +: 8];
      end
      if (m_axi_arvalid && m_axi_arready) begin ar_got <= 1'b1; ar_a <= m_axi_araddr; end
      else if (m_axi_rvalid && m_axi_rready) ar_got <= 1'b0;
    end
  end
  // protocol monitor: pending valids/payloads stay put, and drop right after their handshake
  logic allow_drop = 1'b0;
  int stab_err = 0;
  logic aw_pend, w_pend, ar_pend, aw_hsp, w_hsp, ar_hsp;
  logic [31:0] aw_pa, w_pd, ar_pa;
  always @(posedge clk) begin
    if (!rst && !allow_drop &&
        ((aw_pend && (!m_axi_awvalid || m_axi_awaddr != aw_pa)) ||
         (w_pend && (!m_axi_wvalid || m_axi_wdata != w_pd)) ||
         (ar_pend && (!m_axi_arvalid || m_axi_araddr != ar_pa)) ||
         (aw_hsp && m_axi_awvalid) || (w_hsp && m_axi_wvalid) || (ar_hsp && m_axi_arvalid)))
      stab_err <= stab_err + 1;
    aw_pend <= !rst && m_axi_awvalid && !m_axi_awready;
    w_pend  <= !rst && m_axi_wvalid && !m_axi_wready;
    ar_pend <= !rst && m_axi_arvalid && !m_axi_arready;
    aw_hsp  <= !rst && m_axi_awvalid && m_axi_awready;
    w_hsp   <= !rst && m_axi_wvalid && m_axi_wready;
    ar_hsp  <= !rst && m_axi_arvalid && m_axi_arready;
    aw_pa <= m_axi_awaddr;
    w_pd  <= m_axi_wdata;
    ar_pa <= m_axi_araddr;
  end
  int checks = 0, errors = 0;
  logic [31:0] mdl_mem [16];
  logic [31:0] last_rd;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) mdl_mem[a[5:2]][i*8 +: 8] = d[i*8 +: 8];
  endtask
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int lat, output int awc, output int wc);
    int n;
    @(negedge clk);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin checks++; errors++; $display("FAIL accept_wait actual=busy expected=ready"); end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0; awc = -1; wc = -1;
    do begin
      @(negedge clk);
      lat++;
      if (m_axi_awvalid && m_axi_awready && awc < 0) awc = lat;
      if (m_axi_wvalid && m_axi_wready && wc < 0) wc = lat;
    end while (!rsp_valid && lat < 100);
    if (!rsp_valid) begin checks++; errors++; $display("FAIL rsp_wait actual=none expected=rsp_valid"); end
  endtask
  typedef struct {
    logic wr; logic [31:0] a, d; logic [3:0] s;
    int awd, wd, bd, ard, rd; logic [1:0] sr;
    logic [31:0] erd; logic [1:0] ersp; int elat;
  } vec_t;
  vec_t tbl [6];
  initial begin
    int lat, awc, wc, n, el, seen;
    logic wr;
    logic [31:0] a, d;
    logic [3:0] s;
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, awc, wc, n, el, seen;
    logic wr;
    logic [31:0] a, d;
    logic [3:0] s;
    tbl[0] = '{1'b1, 32'h4, 32'h12AA,     4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        2'b00, 3};
    tbl[1] = '{1'b0, 32'h4, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h12AA,     2'b00, 3};
    tbl[2] = '{1'b1, 32'h8, 32'hDEADBEEF, 4'h5, 3, 0, 1, 0, 0, 2'b00, 32'h12AA,     2'b00, 7};
    tbl[3] = '{1'b0, 32'h8, 32'h0,        4'h0, 0, 0, 0, 2, 1, 2'b00, 32'h00AD00EF, 2'b00, 6};
    tbl[4] = '{1'b1, 32'hC, 32'h11223344, 4'h8, 0, 2, 0, 0, 0, 2'b01, 32'h00AD00EF, 2'b01, 5};
    tbl[5] = '{1'b0, 32'hC, 32'h0,        4'h0, 0, 0, 0, 0, 3, 2'b11, 32'h11000000, 2'b11, 6};
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    last_rd = '0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_timeout, rsp_resp}), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_payload", {m_axi_awaddr, m_axi_wdata}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      aw_d = tbl[i].awd; w_d = tbl[i].wd; b_d = tbl[i].bd; ar_d = tbl[i].ard; r_d = tbl[i].rd;
      sresp = tbl[i].sr;
      do_cmd(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].s, lat, awc, wc);
      chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].elat));
      chk($sformatf("tbl%0d_resp", i), 64'(rsp_resp), 64'(tbl[i].ersp));
      chk($sformatf("tbl%0d_rdata", i), 64'(rsp_rdata), 64'(tbl[i].erd));
      chk($sformatf("tbl%0d_timeout", i), 64'(rsp_timeout), 64'd0);
      if (tbl[i].wr) begin
        chk($sformatf("tbl%0d_aw_hs", i), 64'(awc), 64'(1 + tbl[i].awd));
        chk($sformatf("tbl%0d_w_hs", i), 64'(wc), 64'(1 + tbl[i].wd));
        mdl_write(tbl[i].a, tbl[i].d, tbl[i].s);
      end else last_rd = tbl[i].erd;
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), 64'(rsp_valid), 64'd0);
    end
    for (int k = 0; k < 30; k++) begin
      wr = 1'($urandom_range(0, 1));
      a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      d = $urandom;
      s = 4'($urandom);
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
      sresp = 2'($urandom);
      do_cmd(wr, a, d, s, lat, awc, wc);
      el = wr ? ((aw_d > w_d ? aw_d : w_d) + 3 + b_d) : (ar_d + r_d + 3);
      if (wr) mdl_write(a, d, s); else last_rd = mdl_mem[a[5:2]];
      chk($sformatf("rnd%0d_lat", k), 64'(lat), 64'(el));
      chk($sformatf("rnd%0d_resp", k), 64'(rsp_resp), 64'(sresp));
      chk($sformatf("rnd%0d_rdata", k), 64'(rsp_rdata), 64'(last_rd));
      chk($sformatf("rnd%0d_timeout", k), 64'(rsp_timeout), 64'd0);
    end
    aw_d = 0; w_d = 0; b_d = 0; ar_d = 0; r_d = 14; sresp = 2'b00;
    do_cmd(1'b0, 32'h4, 32'h0, 4'h0, lat, awc, wc);
    last_rd = mdl_mem[1];
    chk("edge_win_lat", 64'(lat), 64'(TO + 1));
    chk("edge_win_timeout", 64'(rsp_timeout), 64'd0);
    chk("edge_win_rdata", 64'(rsp_rdata), 64'(last_rd));
    r_d = 15;
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0, lat, awc, wc);
    chk("edge_to_lat", 64'(lat), 64'(TO + 1));
    chk("edge_to_flags", 64'({rsp_timeout, rsp_resp}), 64'b110);
    chk("edge_to_rdata", 64'(rsp_rdata), 64'(last_rd));
    r_d = 0;
    do_cmd(1'b0, 32'h8, 32'h0, 4'h0, lat, awc, wc);
    last_rd = mdl_mem[2];
    chk("recover_lat", 64'(lat), 64'd3);
    chk("recover_rdata", 64'(rsp_rdata), 64'(last_rd));
    allow_drop = 1'b1; hang_ar = 1'b1;
    do_cmd(1'b0, 32'h0, 32'h0, 4'h0, lat, awc, wc);
    chk("ar_to_lat", 64'(lat), 64'(TO + 1));
    chk("ar_to_flags", 64'({rsp_timeout, rsp_resp}), 64'b110);
    chk("ar_to_rdata", 64'(rsp_rdata), 64'(last_rd));
    chk("ar_to_arvalid", 64'(m_axi_arvalid), 64'd0);
    @(negedge clk);
    chk("ar_to_after", 64'({m_axi_arvalid, rsp_valid, rsp_timeout}), 64'd0);
    allow_drop = 1'b0; hang_ar = 1'b0;
    hang_b = 1'b1;
    do_cmd(1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, lat, awc, wc);
    chk("b_to_lat", 64'(lat), 64'(TO + 1));
    chk("b_to_flags", 64'({rsp_timeout, rsp_resp}), 64'b110);
    chk("b_to_bready", 64'(m_axi_bready), 64'd0);
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 32'h14; cmd_wdata = 32'h5555AAAA; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_bready", 64'(m_axi_bready), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({m_axi_bready, m_axi_awvalid, m_axi_wvalid, rsp_valid, rsp_timeout}), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_payload", {m_axi_awaddr, m_axi_wdata}, 64'd0);
    chk("mid_rst_rsp", {30'd0, rsp_resp, rsp_rdata}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; hang_b = 1'b0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = '0;
    last_rd = '0;
    seen = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("mid_rst_no_rsp", 64'(seen), 64'd0);
    do_cmd(1'b1, 32'h14, 32'hCAFE0001, 4'hF, lat, awc, wc);
    mdl_write(32'h14, 32'hCAFE0001, 4'hF);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_flags", 64'({rsp_timeout, rsp_resp}), 64'd0);
    @(negedge clk);
    cmd_write = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'h8105; cmd_wstrb = 4'hF; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_write = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 50);
    mdl_write(32'hC, 32'h8105, 4'hF);
    chk("b2b_wlat", 64'(n), 64'd3);
    chk("b2b_ready_in_rsp", 64'(cmd_ready), 64'd1);
    chk("b2b_wresp", 64'(rsp_resp), 64'd0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepted", 64'({cmd_ready, m_axi_arvalid}), 64'b01);
    n = 1;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("b2b_rlat", 64'(n), 64'd3);
    chk("b2b_rdata", 64'(rsp_rdata), 64'(mdl_mem[3]));
    chk("b2b_timeout", 64'(rsp_timeout), 64'd0);
    @(negedge clk);
    chk("stability", 64'(stab_err), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
